alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu4_core.sv | 50 +++++
 rtl/alu_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data width, op codes,
// FSM states and the captured command record.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;
  localparam int NUM_REQ = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_NOT = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_LT  = 3'b110,
    OP_EQ  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  typedef struct packed {
    alu_op_e           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu4_core.sv
// Purely combinational 4-bit ALU. Every flag not meaningful for the selected
// op is forced to zero so nothing leaks between operations.
module alu4_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] s,
  output logic              eq,
  output logic              lt,
  output logic              ovf,
  output logic              carry
);

  logic [DATA_W:0] sum_ext;
  logic [DATA_W:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    s     = '0;
    eq    = 1'b0;
    lt    = 1'b0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        s     = sum_ext[DATA_W-1:0];
        carry = sum_ext[DATA_W];
        ovf   = (a[DATA_W-1] == b[DATA_W-1]) && (sum_ext[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        s     = diff_ext[DATA_W-1:0];
        // The extended MSB is the borrow, so carry is its complement.
        carry = ~diff_ext[DATA_W];
        ovf   = (a[DATA_W-1] != b[DATA_W-1]) && (diff_ext[DATA_W-1] != a[DATA_W-1]);
      end
      OP_NOT: s = ~a;
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_XOR: s = a ^ b;
      OP_LT:  lt = (a < b);
      OP_EQ:  eq = (a == b);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU: accept, execute,
// then hold the registered response until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_s,
  output logic              rsp_eq,
  output logic              rsp_lt,
  output logic              rsp_ovf,
  output logic              rsp_carry,
  output logic              busy
);

  arb_state_e        state_reg;
  alu_cmd_t          cmd_reg;
  logic              id_reg;
  logic              last_grant_reg;

  logic [NUM_REQ-1:0] valid_vec;
  logic [NUM_REQ-1:0] grant_vec;
  logic [NUM_REQ-1:0] ready_vec;
  alu_cmd_t           cmd_vec [NUM_REQ];
  logic               accept;
  logic               sel_id;

  logic [DATA_W-1:0] alu_s;
  logic              alu_eq;
  logic              alu_lt;
  logic              alu_ovf;
  logic              alu_carry;

  assign valid_vec  = {req1_valid, req0_valid};
  assign cmd_vec[0] = {req0_op, req0_a, req0_b};
  assign cmd_vec[1] = {req1_op, req1_a, req1_b};

  // last_grant_reg resets to 1 so that req0 wins the first tie.
  always_comb begin
    grant_vec = valid_vec;
    if (&valid_vec) begin
      grant_vec = last_grant_reg ? 2'b01 : 2'b10;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign ready_vec[gi] = rst && (state_reg == ST_IDLE) && grant_vec[gi];
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign accept     = |ready_vec;
  assign sel_id     = grant_vec[1];

  alu4_core u_alu (
    .a     (cmd_reg.a),
    .b     (cmd_reg.b),
    .op    (cmd_reg.op),
    .s     (alu_s),
    .eq    (alu_eq),
    .lt    (alu_lt),
    .ovf   (alu_ovf),
    .carry (alu_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      cmd_reg        <= '0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      busy           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_s          <= '0;
      rsp_eq         <= 1'b0;
      rsp_lt         <= 1'b0;
      rsp_ovf        <= 1'b0;
      rsp_carry      <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            cmd_reg        <= cmd_vec[sel_id];
            id_reg         <= sel_id;
            last_grant_reg <= sel_id;
            state_reg      <= ST_EXEC;
            busy           <= 1'b1;
          end
        end
        ST_EXEC: begin
          rsp_id    <= id_reg;
          rsp_s     <= alu_s;
          rsp_eq    <= alu_eq;
          rsp_lt    <= alu_lt;
          rsp_ovf   <= alu_ovf;
          rsp_carry <= alu_carry;
          rsp_valid <= 1'b1;
          state_reg <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations plus
// hand-written sequences for round-robin, response hold and mid-op reset.
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_s;
  logic       rsp_eq, rsp_lt, rsp_ovf, rsp_carry;
  logic       busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_eq     (rsp_eq),
    .rsp_lt     (rsp_lt),
    .rsp_ovf    (rsp_ovf),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       eq;
    logic       lt;
    logic       ovf;
    logic       carry;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    if (id == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    #1;
    chk($sformatf("v%0d_ready_win", i), (v.id == 0) ? req0_ready : req1_ready, 1);
    chk($sformatf("v%0d_ready_other", i), (v.id == 0) ? req1_ready : req0_ready, 0);
    chk($sformatf("v%0d_idle_busy", i), busy, 0);
    @(posedge clk);
    @(negedge clk);
    set_req(v.id, 1'b0, 3'd0, 4'd0, 4'd0);
    chk($sformatf("v%0d_exec_valid", i), rsp_valid, 0);
    chk($sformatf("v%0d_exec_busy", i), busy, 1);
    @(negedge clk);
    chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
    chk($sformatf("v%0d_rsp_id", i), rsp_id, v.id);
    chk($sformatf("v%0d_s", i), rsp_s, v.s);
    chk($sformatf("v%0d_eq", i), rsp_eq, v.eq);
    chk($sformatf("v%0d_lt", i), rsp_lt, v.lt);
    chk($sformatf("v%0d_ovf", i), rsp_ovf, v.ovf);
    chk($sformatf("v%0d_carry", i), rsp_carry, v.carry);
    $display("txn %0d: id=%0d op=%0d a=%0d b=%0d -> s=%0d eq=%0d lt=%0d ovf=%0d carry=%0d",
             i, v.id, v.op, v.a, v.b, rsp_s, rsp_eq, rsp_lt, rsp_ovf, rsp_carry);
  endtask

  initial begin
    //           id op      a      b      s      eq    lt    ovf   carry
    vecs[0]  = '{0, 3'b000, 4'd7,  4'd1,  4'd8,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1, 3'b001, 4'd3,  4'd5,  4'd14, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1, 3'b001, 4'd8,  4'd1,  4'd7,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{0, 3'b110, 4'd2,  4'd9,  4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1, 3'b111, 4'd5,  4'd5,  4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{0, 3'b011, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 3'b010, 4'd5,  4'd0,  4'd10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{0, 3'b100, 4'd12, 4'd3,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1, 3'b101, 4'd12, 4'd10, 4'd6,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{0, 3'b111, 4'd5,  4'd6,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1, 3'b110, 4'd9,  4'd2,  4'd0,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{0, 3'b001, 4'd5,  4'd5,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1, 3'b000, 4'd15, 4'd1,  4'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{0, 3'b001, 4'd0,  4'd1,  4'd15, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1, 3'b000, 4'd9,  4'd8,  4'd1,  1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    set_req(1, 1'b0, 3'd0, 4'd0, 4'd0);

    // Reset state, with a request presented while reset is held.
    repeat (2) @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_s", rsp_s, 0);
    chk("rst_rsp_id", rsp_id, 0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i);

    // Reset during EXEC aborts the operation; outputs clear without a clock edge.
    @(negedge clk);
    set_req(0, 1'b1, 3'b000, 4'd7, 4'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 4'd0, 4'd0);
    chk("abort_exec_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_id", rsp_id, 0);
    chk("abort_rsp_s", rsp_s, 0);
    chk("abort_carry", rsp_carry, 0);
    chk("abort_ovf", rsp_ovf, 0);
    req0_valid = 1'b1;
    #1;
    chk("abort_ready0_in_reset", req0_ready, 0);
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("abort_no_stale_%0d", c), rsp_valid, 0);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("abort_tie_ready0", req0_ready, 1);
    chk("abort_tie_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("txn abort: reset in EXEC, outputs cleared, req0 wins next tie");

    // Response held for 5 cycles while both requesters wait.
    @(negedge clk);
    set_req(0, 1'b1, 3'b000, 4'd3, 4'd4);
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b1, 3'b000, 4'd1, 4'd1);
    #1;
    chk("hold_exec_ready0", req0_ready, 0);
    chk("hold_exec_ready1", req1_ready, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("hold_valid_%0d", c), rsp_valid, 1);
      chk($sformatf("hold_s_%0d", c), rsp_s, 7);
      chk($sformatf("hold_id_%0d", c), rsp_id, 0);
      chk($sformatf("hold_ready0_%0d", c), req0_ready, 0);
      chk($sformatf("hold_ready1_%0d", c), req1_ready, 0);
      chk($sformatf("hold_busy_%0d", c), busy, 1);
      if (c < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_busy", busy, 0);
    chk("hold_release_valid", rsp_valid, 0);
    chk("hold_release_s_kept", rsp_s, 7);
    chk("hold_release_ready1", req1_ready, 1);
    chk("hold_release_ready0", req0_ready, 0);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("txn hold: response held 5 cycles then released");

    // Round-robin with both requesters continuously valid.
    reset_dut();
    set_req(0, 1'b1, 3'b000, 4'd1, 4'd1);
    set_req(1, 1'b1, 3'b000, 4'd2, 4'd2);
    begin
      int n;
      int last_c;
      n = 0;
      last_c = 0;
      for (int c = 0; c < 30 && n < 4; c++) begin
        @(negedge clk);
        if (rsp_valid) begin
          chk($sformatf("rr_id_%0d", n), rsp_id, n % 2);
          chk($sformatf("rr_s_%0d", n), rsp_s, (n % 2 == 1) ? 4 : 2);
          if (n > 0) chk($sformatf("rr_spacing_%0d", n), c - last_c, 3);
          $display("txn rr%0d: id=%0d s=%0d", n, rsp_id, rsp_s);
          last_c = c;
          n++;
        end
      end
      chk("rr_count", n, 4);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
